phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
- Consumer side of the CPU clock generator. Takes the generator's `fetch` phase level and `alu_clk` strobe and turns each machine cycle into an ordered control sequence: instruction fetch, decode, execute, memory access, write-back.
- Drives the memory request/acknowledge handshake, the IR/PC/ALU/register-file enables, and retirement and fault bookkeeping.
- Sits between the clock generator and the datapath of the multi-cycle MIPS core.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles `mem_req` may wait for `mem_ack` before a bus error.
- TO_W, 4: width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- fetch, input, 1: phase level from the clock generator; a rising edge starts a machine cycle.
- alu_clk, input, 1: one-clk strobe from the clock generator; gates DECODE→EXEC.
- op_class, input, 3: class of the decoded instruction. 0=ALU, 1=LOAD, 2=STORE, 3=BRANCH, 4=HALT, 5–7=NOP.
- alu_zero, input, 1: ALU zero flag, valid during EXEC.
- mem_ack, input, 1: memory acknowledge.
- mem_req, output, 1: memory request.
- mem_we, output, 1: memory write enable, meaningful only while `mem_req`=1.
- ir_load, output, 1: one-clk pulse, load the IR.
- pc_inc, output, 1: one-clk pulse, PC+4.
- pc_load, output, 1: one-clk pulse, take the branch target.
- alu_en, output, 1: one-clk pulse, ALU operate.
- rf_we, output, 1: one-clk pulse, register-file write.
- state, output, 3: current state code.
- retired, output, CNT_W: instructions completed.
- halted, output, 1: core stopped.
- bus_err, output, 1: sticky, memory timeout.
- overrun, output, 1: sticky, `fetch` edge arrived while busy.

Behaviour:
- Reset: every output is 0 and `state`=IDLE. Asynchronous assertion aborts any cycle in flight, and `mem_req` drops immediately.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, DONE=6, HALTED=7.
- Edge detect: `fetch_q` is `fetch` registered, reset value 0. fetch_rise = `fetch` & ~`fetch_q`.
- IDLE: on fetch_rise → FETCH. Otherwise hold.
- FETCH: `mem_req`=1, `mem_we`=0.
  - `mem_ack`=1 at an edge → DECODE. `ir_load` and `pc_inc` are high for exactly the following cycle.
- DECODE: wait for `alu_clk`=1 at an edge → EXEC. `op_class` is latched on that same edge.
- EXEC: `alu_en`=1 for this single cycle. Next state by the latched `op_class`:
  - ALU → WB.
  - LOAD → MEM with `mem_we`=0.
  - STORE → MEM with `mem_we`=1.
  - BRANCH → DONE; `pc_load` pulses for one cycle if `alu_zero`=1 at this edge.
  - HALT → HALTED.
  - NOP (5–7) → DONE.
- MEM: `mem_req`=1, and `mem_we` holds its value for the whole wait.
  - `mem_ack` → WB for LOAD, DONE for STORE.
- WB: `rf_we`=1 for this single cycle → DONE.
- DONE: `retired` increments by 1, wrapping modulo 2^CNT_W → IDLE.
- HALTED: absorbing state. All enables are 0 and `halted`=1. Only reset exits.
- `mem_req` and `mem_we` are decoded from registered state, so they are glitch-free.
- `mem_ack` is ignored outside FETCH and MEM.
- Timeout:
  - The counter clears on entering FETCH or MEM and increments each cycle without ack.
  - When it reaches MEM_TIMEOUT without ack: `bus_err`:=1, state → HALTED, `mem_req` drops.
  - Ack on the same edge the count reaches MEM_TIMEOUT: the ack wins and there is no error.
- Overrun: fetch_rise in any state other than IDLE or HALTED sets `overrun`:=1. The edge is discarded and not queued.
  - fetch_rise in DONE is an overrun; the next cycle requires a fresh edge seen in IDLE.
- `bus_err` and `overrun` clear only on reset.
- `alu_clk` outside DECODE is ignored.

Test Plan:
- Reset, then a fetch edge, `mem_ack` after 2 cycles, `alu_clk`, op_class=0 → states 0,1,1,1,2,3,5,6,0.
  - `ir_load` and `pc_inc` each high 1 cycle; `alu_en` and `rf_we` each high 1 cycle; `retired`=1.
- LOAD then STORE, ack delay 3 each → LOAD: `mem_req` with `mem_we`=0 in FETCH and MEM, `rf_we` pulses.
  - STORE: `mem_we`=1 only in MEM, no `rf_we`; `retired`=2.
- BRANCH with `alu_zero`=1, then `alu_zero`=0 → `pc_load` pulses once in the first case only.
- `mem_ack` withheld in MEM → after 15 cycles `bus_err`=1, `halted`=1, state=7, `mem_req`=0. Further fetch edges have no effect.
- Second fetch edge during DECODE → `overrun`=1, the sequence still completes, `retired` increments once.
  - 65536 retirements wrap `retired` to 0.
- Assert reset while in MEM with `mem_req`=1 → `mem_req`=0 asynchronously and all outputs 0.
  - The sticky flags clear, and the next fetch edge restarts at FETCH.

Source files
------------

// File: rtl/phase_sequencer.sv
// Multi-cycle control sequencer: turns each fetch-phase edge from the clock generator into
// FETCH/DECODE/EXEC/MEM/WB/DONE steps, with memory handshake timeout and sticky fault flags.
module phase_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch,
    input  logic             alu_clk,
    input  logic [2:0]       op_class,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             alu_en,
    output logic             rf_we,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             halted,
    output logic             bus_err,
    output logic             overrun
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_HALTED = 3'd7;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_HALT   = 3'd4;

    // The count reaches MEM_TIMEOUT on the edge where it currently holds MEM_TIMEOUT-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic             fetch_q_r;
    logic             fetch_rise_s;
    logic             busy_s;
    logic             to_last_s;
    logic             timeout_s;
    logic [2:0]       op_r;
    logic [TO_W-1:0]  to_cnt_r;
    logic             ir_load_r;
    logic             pc_inc_r;
    logic             pc_load_r;
    logic             alu_en_r;
    logic             rf_we_r;
    logic [CNT_W-1:0] retired_r;
    logic             halted_r;
    logic             bus_err_r;
    logic             overrun_r;

    assign fetch_rise_s = fetch & ~fetch_q_r;
    assign busy_s       = (state_r != S_IDLE) && (state_r != S_HALTED);
    assign to_last_s    = (to_cnt_r == TO_LAST);

    // Next-state selection, including the memory-timeout escape to HALTED.
    always_comb begin
        state_nxt_s = state_r;
        timeout_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (fetch_rise_s) state_nxt_s = S_FETCH;
                else              state_nxt_s = S_IDLE;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_nxt_s = S_DECODE;
                end else if (to_last_s) begin
                    state_nxt_s = S_HALTED;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (alu_clk) state_nxt_s = S_EXEC;
                else         state_nxt_s = S_DECODE;
            end
            S_EXEC: begin
                case (op_r)
                    OP_ALU:            state_nxt_s = S_WB;
                    OP_LOAD, OP_STORE: state_nxt_s = S_MEM;
                    OP_BRANCH:         state_nxt_s = S_DONE;
                    OP_HALT:           state_nxt_s = S_HALTED;
                    default:           state_nxt_s = S_DONE;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op_r == OP_LOAD) state_nxt_s = S_WB;
                    else                 state_nxt_s = S_DONE;
                end else if (to_last_s) begin
                    state_nxt_s = S_HALTED;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = S_MEM;
                end
            end
            S_WB:     state_nxt_s = S_DONE;
            S_DONE:   state_nxt_s = S_IDLE;
            S_HALTED: state_nxt_s = S_HALTED;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // State, latched opcode, timeout counter, one-cycle strobes and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            fetch_q_r <= 1'b0;
            op_r      <= OP_ALU;
            to_cnt_r  <= '0;
            ir_load_r <= 1'b0;
            pc_inc_r  <= 1'b0;
            pc_load_r <= 1'b0;
            alu_en_r  <= 1'b0;
            rf_we_r   <= 1'b0;
            retired_r <= '0;
            halted_r  <= 1'b0;
            bus_err_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            fetch_q_r <= fetch;
            if ((state_r == S_DECODE) && alu_clk) begin
                op_r <= op_class;
            end
            // Counter is held at zero outside the handshake states, so entry always starts at 0.
            if ((state_r == S_FETCH) || (state_r == S_MEM)) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= '0;
            end
            ir_load_r <= (state_r == S_FETCH) && mem_ack;
            pc_inc_r  <= (state_r == S_FETCH) && mem_ack;
            pc_load_r <= (state_r == S_EXEC) && (op_r == OP_BRANCH) && alu_zero;
            alu_en_r  <= (state_nxt_s == S_EXEC);
            rf_we_r   <= (state_nxt_s == S_WB);
            if (state_r == S_DONE) begin
                retired_r <= retired_r + CNT_W'(1);
            end
            halted_r  <= (state_nxt_s == S_HALTED);
            bus_err_r <= bus_err_r | timeout_s;
            overrun_r <= overrun_r | (fetch_rise_s & busy_s);
        end
    end

    assign state   = state_r;
    assign mem_req = (state_r == S_FETCH) || (state_r == S_MEM);
    assign mem_we  = (state_r == S_MEM) && (op_r == OP_STORE);
    assign ir_load = ir_load_r;
    assign pc_inc  = pc_inc_r;
    assign pc_load = pc_load_r;
    assign alu_en  = alu_en_r;
    assign rf_we   = rf_we_r;
    assign retired = retired_r;
    assign halted  = halted_r;
    assign bus_err = bus_err_r;
    assign overrun = overrun_r;

endmodule
